// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// One radix-2 iteration per cycle; signed ops run on magnitudes with a final sign fixup.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   upper_reg;
  logic [WIDTH-1:0] lower_reg, mcand_reg;
  logic             is_div_reg, neg_q_reg, neg_r_reg, done_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg, hi_next, lo_next;
  logic             done_next, load, step;

  // Operand conditioning on the accepting edge
  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag, a_sel;

  assign a_neg    = op[0] & a[WIDTH-1];
  assign b_neg    = op[0] & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = op[1] & (b == '0);
  // Divide by zero keeps the raw dividend so the remainder comes out as a unchanged
  assign a_sel    = div_zero ? a : a_mag;

  // Shared iteration datapath: {upper, lower} shifts right for multiply, left for divide
  logic [WIDTH:0]   sum, shifted, diff;
  logic [WIDTH:0]   upper_step;
  logic [WIDTH-1:0] lower_step;

  always_comb begin
    sum        = {1'b0, upper_reg[WIDTH-1:0]} + (lower_reg[0] ? {1'b0, mcand_reg} : '0);
    shifted    = {upper_reg[WIDTH-1:0], lower_reg[WIDTH-1]};
    diff       = shifted - {1'b0, mcand_reg};
    upper_step = {1'b0, sum[WIDTH:1]};
    lower_step = {sum[0], lower_reg[WIDTH-1:1]};
    if (is_div_reg) begin
      if (!diff[WIDTH]) begin
        upper_step = diff;
        lower_step = {lower_reg[WIDTH-2:0], 1'b1};
      end else begin
        upper_step = shifted;
        lower_step = {lower_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign-corrected results
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod     = {upper_reg[WIDTH-1:0], lower_reg};
  assign prod_fix = neg_q_reg ? -prod : prod;
  assign quot_fix = neg_q_reg ? -lower_reg : lower_reg;
  assign rem_fix  = neg_r_reg ? -upper_reg[WIDTH-1:0] : upper_reg[WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end else begin
          if (mthi) hi_next = wdata;
          if (mtlo) lo_next = wdata;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        if (!flush) begin
          done_next = 1'b1;
          if (is_div_reg) begin
            hi_next = rem_fix;
            lo_next = quot_fix;
          end else begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg    <= '0;
      upper_reg  <= '0;
      lower_reg  <= '0;
      mcand_reg  <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else if (load) begin
      cnt_reg    <= '0;
      upper_reg  <= '0;
      lower_reg  <= op[1] ? a_sel : b_mag;
      mcand_reg  <= op[1] ? b_mag : a_sel;
      is_div_reg <= op[1];
      neg_q_reg  <= (a_neg ^ b_neg) & ~div_zero;
      neg_r_reg  <= a_neg & ~div_zero;
    end else if (step) begin
      cnt_reg   <= cnt_reg + CW'(1);
      upper_reg <= upper_step;
      lower_reg <= lower_step;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, multi-cycle corner
// sequences, and randomized operations checked against an arithmetic model.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, mthi, mtlo, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] hi, lo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definitions
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, q, r;
    longint p;
    logic [63:0] res;
    sx = x;
    sy = y;
    case (o)
      2'd0: res = {32'b0, x} * {32'b0, y};
      2'd1: begin p = longint'(sx) * longint'(sy); res = p; end
      2'd2: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin q = sx / sy; r = sx % sy; res = {r, q}; end
      end
    endcase
    return res;
  endfunction

  // Issue one op from IDLE; check latency, busy length and result. Returns in the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input string name);
    int k, busy_cnt;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (!done && k < 100) begin
      if (busy) busy_cnt++;
      tick();
      k++;
    end
    chk({name, "_latency"}, 64'(k), 64'(W + 1));
    chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
    chk({name, "_result"}, {hi, lo}, {ehi, elo});
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h) lat=%0d", o, x, y, hi, lo, ehi, elo, k);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk({name, "_done_seen"}, 64'(done), 64'(1));
  endtask

  task automatic watch_no_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk({name, "_no_done"}, 64'(seen), 64'(0));
  endtask

  function automatic logic [W-1:0] pick(input logic allow_zero);
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = allow_zero ? 32'h0 : 32'h1;
      3: v = $urandom_range(0, 20);
      4: v = -$urandom_range(1, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'd1, -32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'd3, -32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd2, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd2, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[6] = '{2'd3, 32'd7, -32'd2, 32'd1, 32'hFFFF_FFFD};
    vecs[7] = '{2'd3, -32'd7, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{2'd0, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780};

    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'd0; a = '0; b = '0; wdata = '0;
    tick();
    tick();
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_busy_done", 64'({busy, done}), 64'h0);
    reset = 1'b1;

    // First op starts on the very first edge after release
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // mthi / mtlo writes in IDLE
    mthi = 1'b1; wdata = 32'h1234;
    tick();
    mthi = 1'b0;
    chk("mthi_idle", 64'(hi), 64'h1234);
    chk("mthi_no_done", 64'(done), 64'h0);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo_both", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    $display("mthi/mtlo writes: hi=%h lo=%h", hi, lo);

    // Flush during CALC leaves HI/LO untouched
    mthi = 1'b1; wdata = 32'h1234;
    tick();
    mthi = 1'b0;
    op = 2'd1; a = -32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_calc_busy", 64'(busy), 64'h0);
    chk("flush_calc_hilo", {hi, lo}, {32'h1234, 32'hA5A5_A5A5});
    watch_no_done("flush_calc");
    $display("flush in CALC: hi=%h lo=%h busy=%0d", hi, lo, busy);

    // start wins over mtlo; mthi ignored while busy
    op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD;
    tick();
    start = 1'b0; mtlo = 1'b0;
    chk("start_mtlo_dropped", 64'(lo), 64'hA5A5_A5A5);
    chk("start_busy", 64'(busy), 64'h1);
    mthi = 1'b1; wdata = 32'hBEEF;
    tick();
    mthi = 1'b0;
    chk("mthi_busy_ignored", 64'(hi), 64'h1234);
    wait_done("mul3x4");
    chk("mul3x4_result", {hi, lo}, {32'd0, 32'd12});
    $display("start+mtlo then mthi busy: hi=%h lo=%h", hi, lo);

    // Flush in IDLE does not block start
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_start", 64'(busy), 64'h1);
    wait_done("flush_idle");
    chk("flush_idle_result", {hi, lo}, {32'd2, 32'd14});
    $display("flush in IDLE with start: hi=%h lo=%h", hi, lo);

    // Flush in FIX: no write, no done
    op = 2'd0; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W) tick();
    chk("in_fix_busy", 64'(busy), 64'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_fix_state", 64'({busy, done}), 64'h0);
    chk("flush_fix_hilo", {hi, lo}, {32'd2, 32'd14});
    watch_no_done("flush_fix");
    $display("flush in FIX: hi=%h lo=%h", hi, lo);

    // Asynchronous reset mid-CALC
    op = 2'd1; a = 32'd7; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    chk("async_reset_hilo", {hi, lo}, 64'h0);
    chk("async_reset_busy_done", 64'({busy, done}), 64'h0);
    #2;
    reset = 1'b1;
    watch_no_done("after_reset");
    chk("after_reset_hilo", {hi, lo}, 64'h0);
    $display("reset mid-op: hi=%h lo=%h busy=%0d", hi, lo, busy);

    // Back-to-back: second start issued in the done cycle
    run_op(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, "b2b_first");
    run_op(2'd3, -32'd9, 32'd4, -32'd1, -32'd2, "b2b_second");

    // Randomized ops, each launched in the previous done cycle
    for (int i = 0; i < 200; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] rx, ry;
      logic [63:0]  e;
      ro = 2'($urandom_range(0, 3));
      rx = pick(1'b1);
      ry = pick(1'b1);
      e  = model(ro, rx, ry);
      run_op(ro, rx, ry, e[63:32], e[31:0], $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and HI/LO width; iteration count equals WIDTH.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2: operation select; 00 multu, 01 mult, 10 divu, 11 div.
REQ-006 The block SHALL have port a, input, WIDTH: multiplicand/dividend; captured on the accepting edge.
REQ-007 The block SHALL have port b, input, WIDTH: multiplier/divisor; captured on the accepting edge.
REQ-008 The block SHALL have port mthi, input, 1: write wdata to HI; honoured only in IDLE.
REQ-009 The block SHALL have port mtlo, input, 1: write wdata to LO; honoured only in IDLE.
REQ-010 The block SHALL have port wdata, input, WIDTH: data for mthi/mtlo.
REQ-011 The block SHALL have port flush, input, 1: synchronous abort of an operation in progress.
REQ-012 The block SHALL have port busy, output, 1: operation in progress; pipeline stalls on HI/LO access while high.
REQ-013 The block SHALL have port done, output, 1: one-cycle pulse when HI/LO receive a result.
REQ-014 The block SHALL have ports hi and lo, output, WIDTH each: architectural HI and LO registers.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC, FIX.
REQ-016 In IDLE with start=1, the accepting edge SHALL latch |a|, |b| (magnitudes only for op[0]=1; otherwise raw), record result signs, clear the iteration counter, and enter CALC.
REQ-017 CALC SHALL perform exactly one iteration per cycle for WIDTH cycles, then enter FIX: radix-2 shift-add for multiply, restoring shift-subtract for divide.
REQ-018 FIX SHALL apply sign correction, write hi/lo, return to IDLE, and assert done for exactly the following cycle.
REQ-019 Latency SHALL be fixed: accept edge T0, hi/lo updated at edge T0+WIDTH+1, done high during the cycle after that edge; busy SHALL be high from after T0 until that same edge.
REQ-020 Multiply SHALL produce the 2*WIDTH-bit product; hi = upper half, lo = lower half; mult SHALL negate the full product when sign(a) XOR sign(b) = 1.
REQ-021 Divide SHALL produce lo = quotient and hi = remainder; div SHALL negate the quotient when signs differ, and the remainder SHALL take the sign of the dividend.
REQ-022 Negation SHALL be two's complement mod 2^WIDTH; div of 0x80000000 by -1 SHALL yield lo = 0x80000000, hi = 0.
REQ-023 Divide by zero (divu or div) SHALL run full latency and yield lo = all ones, hi = a as captured (raw, unsigned), with sign fixup suppressed.
REQ-024 start, mthi and mtlo SHALL be ignored while busy=1.
REQ-025 In IDLE, start SHALL have priority: if start and mthi/mtlo are asserted together, the writes SHALL be dropped.
REQ-026 In IDLE without start, mthi/mtlo SHALL update hi/lo on the next edge; both may be written in the same cycle; done SHALL NOT assert.
REQ-027 flush=1 in CALC or FIX SHALL return the FSM to IDLE on the next edge with hi/lo unchanged and no done pulse; flush in IDLE SHALL have no effect, and start is still honoured.
REQ-028 On the edge that asserts done, a new start SHALL be accepted, permitting back-to-back operations with no bubble beyond the done cycle.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, hi = 0, lo = 0, busy = 0, done = 0, and counter = 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation; no done SHALL be produced after release.
REQ-031 After reset release, the first rising edge SHALL already accept start.

Verification
REQ-032 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> done at T0+34; hi = 0xFFFFFFFE, lo = 0x00000001; busy high for 33 cycles.
REQ-033 mult a=-3, b=5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; div a=-7, b=2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-034 divu a=100, b=0 -> lo = 0xFFFFFFFF, hi = 0x00000064; div a=0x80000000, b=0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-035 mthi wdata=0x1234 in IDLE, then start mult; flush at CALC cycle 10 -> hi stays 0x1234, no done, busy low the next cycle.
REQ-036 mthi during busy is ignored; start and mtlo asserted together in IDLE -> mtlo dropped.
REQ-037 reset pulsed low at CALC cycle 5 -> all outputs 0 immediately; no done afterwards.
REQ-038 Back-to-back start on the done edge -> second result arrives exactly 34 edges later.
